// File: rtl/stat_monitor_if.sv
// Sample stream in, window statistics and health verdict out, for stat_monitor.
interface stat_monitor_if;
  logic       sample_en;
  logic [7:0] ones;
  logic [7:0] change_sign_count;
  logic       clr_sticky;
  logic [7:0] ones_avg;
  logic [7:0] changes_avg;
  logic       win_done;
  logic       alarm;
  logic       bias_seen;
  logic       density_seen;
  logic [1:0] state;

  modport master (
    output sample_en, ones, change_sign_count, clr_sticky,
    input  ones_avg, changes_avg, win_done, alarm, bias_seen, density_seen, state
  );

  modport slave (
    input  sample_en, ones, change_sign_count, clr_sticky,
    output ones_avg, changes_avg, win_done, alarm, bias_seen, density_seen, state
  );
endinterface

// File: rtl/stat_monitor.sv
// Windowed health monitor: averages ones/transition counts over WINDOW samples and
// drives a WARMUP/OK/SUSPECT/ALARM verdict FSM with sticky cause flags.
module stat_monitor #(
  parameter int WORD_SIZE   = 32,
  parameter int WINDOW      = 16,
  parameter int SKIP        = 6,
  parameter int ONES_LO     = 12,
  parameter int ONES_HI     = 20,
  parameter int MIN_CHANGES = 8,
  parameter int ALARM_CNT   = 3,
  parameter int CLEAR_CNT   = 3
) (
  input logic          clk,
  input logic          rst_n,
  stat_monitor_if.slave bus
);
  localparam int L     = $clog2(WINDOW);
  localparam int ACC_W = 8 + L;
  localparam int SK_W  = $clog2(SKIP + 2);
  localparam int CNT_W = 8;

  if (WORD_SIZE < 1 || WORD_SIZE > 255 || WINDOW < 2 || WINDOW > 256 ||
      (1 << L) != WINDOW || ALARM_CNT < 1 || CLEAR_CNT < 1) begin : g_param_check
    $error("stat_monitor: illegal parameter set");
  end

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    OK      = 2'd1,
    SUSPECT = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [SK_W-1:0]    skip_cnt, skip_nxt;
  logic [CNT_W-1:0]   bad_cnt, bad_nxt, good_cnt, good_nxt;
  logic [L-1:0]       win_cnt;
  logic [ACC_W-1:0]   sum_ones, sum_chg, sum_ones_nxt, sum_chg_nxt;
  logic [7:0]         ones_avg_q, changes_avg_q;
  logic               win_done_q, alarm_q, bias_q, dens_q;
  logic               acc_en, ones_bad, dens_bad, bad;

  // With SKIP=0 the very first edge already counts toward the first window.
  assign acc_en       = bus.sample_en && (state_q != WARMUP || SKIP == 0);
  assign sum_ones_nxt = sum_ones + ACC_W'(bus.ones);
  assign sum_chg_nxt  = sum_chg + ACC_W'(bus.change_sign_count);

  assign ones_bad = (ones_avg_q < 8'(ONES_LO)) || (ones_avg_q > 8'(ONES_HI));
  assign dens_bad = changes_avg_q < 8'(MIN_CHANGES);
  assign bad      = ones_bad || dens_bad;

  always_comb begin
    state_nxt = state_q;
    skip_nxt  = skip_cnt;
    bad_nxt   = bad_cnt;
    good_nxt  = good_cnt;
    case (state_q)
      WARMUP: begin
        if (SKIP == 0) begin
          state_nxt = OK;
        end else if (bus.sample_en) begin
          if (skip_cnt == SK_W'(SKIP - 1)) begin
            state_nxt = OK;
            skip_nxt  = '0;
          end else begin
            skip_nxt = skip_cnt + 1'b1;
          end
        end
      end
      OK: begin
        if (win_done_q && bad) begin
          if (ALARM_CNT == 1) begin
            state_nxt = ALARM;
            good_nxt  = '0;
          end else begin
            state_nxt = SUSPECT;
            bad_nxt   = 8'd1;
          end
        end
      end
      SUSPECT: begin
        if (win_done_q) begin
          if (!bad) begin
            state_nxt = OK;
            bad_nxt   = '0;
          end else if (bad_cnt + 8'd1 == CNT_W'(ALARM_CNT)) begin
            state_nxt = ALARM;
            bad_nxt   = '0;
            good_nxt  = '0;
          end else begin
            bad_nxt = bad_cnt + 8'd1;
          end
        end
      end
      ALARM: begin
        if (win_done_q) begin
          if (bad) begin
            good_nxt = '0;
          end else if (good_cnt + 8'd1 == CNT_W'(CLEAR_CNT)) begin
            state_nxt = OK;
            good_nxt  = '0;
          end else begin
            good_nxt = good_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WARMUP;
      skip_cnt      <= '0;
      bad_cnt       <= '0;
      good_cnt      <= '0;
      win_cnt       <= '0;
      sum_ones      <= '0;
      sum_chg       <= '0;
      ones_avg_q    <= '0;
      changes_avg_q <= '0;
      win_done_q    <= 1'b0;
      alarm_q       <= 1'b0;
      bias_q        <= 1'b0;
      dens_q        <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      skip_cnt   <= skip_nxt;
      bad_cnt    <= bad_nxt;
      good_cnt   <= good_nxt;
      alarm_q    <= (state_nxt == ALARM);
      win_done_q <= 1'b0;
      if (acc_en) begin
        win_cnt <= win_cnt + 1'b1;
        if (win_cnt == '1) begin
          ones_avg_q    <= 8'(sum_ones_nxt >> L);
          changes_avg_q <= 8'(sum_chg_nxt >> L);
          win_done_q    <= 1'b1;
          sum_ones      <= '0;
          sum_chg       <= '0;
        end else begin
          sum_ones <= sum_ones_nxt;
          sum_chg  <= sum_chg_nxt;
        end
      end
      // A cause observed on this edge outranks a simultaneous clear.
      if (win_done_q && ones_bad)  bias_q <= 1'b1;
      else if (bus.clr_sticky)     bias_q <= 1'b0;
      if (win_done_q && dens_bad)  dens_q <= 1'b1;
      else if (bus.clr_sticky)     dens_q <= 1'b0;
    end
  end

  assign bus.ones_avg     = ones_avg_q;
  assign bus.changes_avg  = changes_avg_q;
  assign bus.win_done     = win_done_q;
  assign bus.alarm        = alarm_q;
  assign bus.bias_seen    = bias_q;
  assign bus.density_seen = dens_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_stat_monitor.sv
// Bench for stat_monitor: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a sample-queue reference model.
module tb_stat_monitor;
  localparam int WINDOW = 4, SKIP = 2, ONES_LO = 12, ONES_HI = 20, MIN_CHANGES = 4;
  localparam int ALARM_CNT = 2, CLEAR_CNT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stat_monitor_if bus();

  stat_monitor #(
    .WORD_SIZE(32), .WINDOW(WINDOW), .SKIP(SKIP), .ONES_LO(ONES_LO), .ONES_HI(ONES_HI),
    .MIN_CHANGES(MIN_CHANGES), .ALARM_CNT(ALARM_CNT), .CLEAR_CNT(CLEAR_CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: samples of the open window kept in queues, averages by division.
  int m_state = 0, m_skipped = 0, m_streak = 0;
  int m_oa = 0, m_ca = 0;
  bit m_wd = 0, m_bias = 0, m_dens = 0;
  int q_ones[$];
  int q_chg[$];
  int old_state, so, sc;
  bit ob, db, bd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_skipped = 0; m_streak = 0; m_oa = 0; m_ca = 0;
      m_wd = 0; m_bias = 0; m_dens = 0;
      q_ones.delete(); q_chg.delete();
    end else begin
      old_state = m_state;
      ob = m_wd && (m_oa < ONES_LO || m_oa > ONES_HI);
      db = m_wd && (m_ca < MIN_CHANGES);
      bd = ob || db;
      if (m_wd) begin
        case (m_state)
          1: if (bd) begin
               m_streak = 1;
               if (m_streak >= ALARM_CNT) begin m_state = 3; m_streak = 0; end
               else m_state = 2;
             end
          2: if (bd) begin
               m_streak++;
               if (m_streak >= ALARM_CNT) begin m_state = 3; m_streak = 0; end
             end else begin
               m_state = 1; m_streak = 0;
             end
          3: if (!bd) begin
               m_streak++;
               if (m_streak >= CLEAR_CNT) begin m_state = 1; m_streak = 0; end
             end else m_streak = 0;
          default: ;
        endcase
      end
      m_bias = ob ? 1'b1 : (bus.clr_sticky ? 1'b0 : m_bias);
      m_dens = db ? 1'b1 : (bus.clr_sticky ? 1'b0 : m_dens);
      m_wd = 0;
      if (old_state == 0 && SKIP > 0) begin
        if (bus.sample_en) begin
          m_skipped++;
          if (m_skipped == SKIP) m_state = 1;
        end
      end else begin
        if (old_state == 0) m_state = 1;
        if (bus.sample_en) begin
          q_ones.push_back(int'(bus.ones));
          q_chg.push_back(int'(bus.change_sign_count));
          if (q_ones.size() == WINDOW) begin
            so = 0; sc = 0;
            foreach (q_ones[i]) begin so += q_ones[i]; sc += q_chg[i]; end
            m_oa = so / WINDOW; m_ca = sc / WINDOW; m_wd = 1;
            q_ones.delete(); q_chg.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("state", int'(bus.state), m_state);
    chk("ones_avg", int'(bus.ones_avg), m_oa);
    chk("changes_avg", int'(bus.changes_avg), m_ca);
    chk("win_done", int'(bus.win_done), int'(m_wd));
    chk("alarm", int'(bus.alarm), int'(m_state == 3));
    chk("bias_seen", int'(bus.bias_seen), int'(m_bias));
    chk("density_seen", int'(bus.density_seen), int'(m_dens));
  end

  // Drive one cycle of inputs and return just after the edge that consumes them.
  task automatic put(input bit en, input int o, input int c, input bit clr);
    bus.sample_en = en;
    bus.ones = 8'(o);
    bus.change_sign_count = 8'(c);
    bus.clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic window(input int o0, o1, o2, o3, input int c0, c1, c2, c3);
    put(1, o0, c0, 0); put(1, o1, c1, 0); put(1, o2, c2, 0); put(1, o3, c3, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.sample_en = 0; bus.ones = '0; bus.change_sign_count = '0; bus.clr_sticky = 0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_alarm", int'(bus.alarm), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Warm-up then a clean window.
    put(1, 16, 10, 0);
    chk("warmup_state0", int'(bus.state), 0);
    put(1, 16, 10, 0);
    chk("warmup_state1", int'(bus.state), 1);
    window(16, 16, 16, 16, 10, 10, 10, 10);
    chk("w1_win_done", int'(bus.win_done), 1);
    chk("w1_ones_avg", int'(bus.ones_avg), 16);
    chk("w1_changes_avg", int'(bus.changes_avg), 10);
    chk("w1_alarm", int'(bus.alarm), 0);
    chk("model_w1_avg", m_oa, 16);
    put(0, 0, 0, 0);
    chk("w1_pulse_end", int'(bus.win_done), 0);

    // Biased windows drive OK -> SUSPECT -> ALARM.
    window(30, 30, 30, 31, 10, 10, 10, 10);
    chk("bias_ones_avg", int'(bus.ones_avg), 30);
    put(0, 0, 0, 0);
    chk("bias_state_suspect", int'(bus.state), 2);
    chk("bias_seen_set", int'(bus.bias_seen), 1);
    window(30, 30, 30, 31, 10, 10, 10, 10); put(0, 0, 0, 0);
    chk("bias_state_alarm", int'(bus.state), 3);
    chk("bias_alarm_on", int'(bus.alarm), 1);

    // Recovery with an interrupting bad window.
    window(16, 16, 16, 16, 10, 10, 10, 10); put(0, 0, 0, 0);
    chk("clear1_alarm", int'(bus.alarm), 1);
    window(30, 30, 30, 30, 10, 10, 10, 10); put(0, 0, 0, 0);
    window(16, 16, 16, 16, 10, 10, 10, 10); put(0, 0, 0, 0);
    chk("clear_restart_alarm", int'(bus.alarm), 1);
    window(16, 16, 16, 16, 10, 10, 10, 10); put(0, 0, 0, 0);
    chk("clear2_alarm", int'(bus.alarm), 0);
    chk("clear2_state", int'(bus.state), 1);
    chk("model_state_ok", m_state, 1);

    // Low density; clear coincident with the set keeps density, drops bias.
    window(16, 16, 16, 16, 3, 3, 4, 4);
    chk("dens_changes_avg", int'(bus.changes_avg), 3);
    put(0, 0, 0, 1);
    chk("dens_seen_wins", int'(bus.density_seen), 1);
    chk("dens_bias_cleared", int'(bus.bias_seen), 0);
    put(0, 0, 0, 1);
    chk("dens_cleared", int'(bus.density_seen), 0);
    window(12, 12, 12, 12, 4, 4, 4, 4); put(0, 0, 0, 0);
    chk("band_edge_ok", int'(bus.state), 1);

    // Gapped feed gives the same averages as continuous feed.
    put(1, 16, 8, 0); put(0, 99, 0, 0); put(1, 17, 9, 0); put(0, 0, 99, 0);
    put(1, 18, 10, 0); put(0, 0, 0, 0); put(1, 19, 11, 0);
    chk("gap_win_done", int'(bus.win_done), 1);
    chk("gap_ones_avg", int'(bus.ones_avg), 17);
    chk("gap_changes_avg", int'(bus.changes_avg), 9);
    put(0, 0, 0, 0);

    // Reset mid-window is immediate and restarts warm-up.
    put(1, 30, 10, 0); put(1, 30, 10, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_ones_avg", int'(bus.ones_avg), 0);
    chk("midrst_changes_avg", int'(bus.changes_avg), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    put(1, 20, 4, 0);
    chk("rewarm_state0", int'(bus.state), 0);
    put(1, 20, 4, 0);
    window(20, 20, 20, 20, 4, 4, 4, 4);
    chk("rewarm_ones_avg", int'(bus.ones_avg), 20);
    put(0, 0, 0, 0);
    chk("rewarm_state_ok", int'(bus.state), 1);

    // Random traffic around the band limits.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end
      put($urandom_range(0, 9) < 7, $urandom_range(6, 26), $urandom_range(1, 12),
          $urandom_range(0, 19) == 0);
    end

    put(0, 0, 0, 0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
